// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, transmit FSM states, bit index sizing.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int BIT_IDX_W = $clog2(DATA_BITS);

  // Index of the final data bit; the DATA state leaves for STOP once it is on the line.
  localparam logic [BIT_IDX_W-1:0] LAST_BIT_IDX = BIT_IDX_W'(DATA_BITS - 1);

  // The state name is the kind of bit currently driven on the serial line.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with registered count; depth must be a power of two (>= 2).
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module uart_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  // Flags come from the pre-edge count, so a byte written this cycle cannot be read this cycle.
  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH_CNT);
  assign count     = count_q;
  assign dout      = mem_q[rd_ptr_q];
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;

  // Next-state for storage, pointers (wrap modulo DEPTH) and occupancy count.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Register FIFO state; reset empties the buffer and clears its contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: buffers host bytes in a FIFO and shifts each one out
// LSB first, one bit per clk_en pulse, with back-to-back frames when queued.
module uart_tx
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic       wr_en,
  input  logic [7:0] din,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       ovf
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [DATA_BITS-1:0] fifo_dout_s;
  logic                 fifo_empty_s;
  logic                 fifo_full_s;
  logic [CNT_W-1:0]     fifo_count_s;
  logic                 pop_s;

  tx_state_t            state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BIT_IDX_W-1:0] idx_q, idx_d;
  logic                 tx_q, tx_d;
  logic                 ovf_q, ovf_d;

  uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_en),
    .pop   (pop_s),
    .din   (din),
    .dout  (fifo_dout_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s),
    .count (fifo_count_s)
  );

  // Status flags are decoded from registered state only, never from inputs.
  assign busy = (state_q != IDLE) | (fifo_count_s != '0);
  assign full = fifo_full_s;
  assign tx   = tx_q;
  assign ovf  = ovf_q;

  // Next-state, shift data and next line level; the line only moves on clk_en.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    tx_d    = tx_q;
    pop_s   = 1'b0;
    ovf_d   = wr_en & fifo_full_s;
    if (clk_en) begin
      case (state_q)
        IDLE, STOP: begin
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            shift_d = fifo_dout_s;
            idx_d   = '0;
            state_d = START;
            tx_d    = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end
        START: begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = shift_q[0];
        end
        DATA: begin
          if (idx_q != LAST_BIT_IDX) begin
            idx_d   = idx_q + 1'b1;
            tx_d    = shift_q[idx_d];
          end else begin
            state_d = STOP;
            tx_d    = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      endcase
    end else begin
      state_d = state_q;
      tx_d    = tx_q;
    end
  end

  // Transmit FSM registers; reset aborts any frame and returns the line to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: reset, idle, single frame, back-to-back frames,
// FIFO overflow, mid-frame reset, and a dropped write during a STOP->START pop.
module tb_uart_tx;

  localparam int GAP = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic       wr_en;
  logic [7:0] din;
  logic       tx;
  logic       busy;
  logic       full;
  logic       ovf;

  int total = 0;
  int bad   = 0;

  logic [9:0] exp_a5;

  uart_tx #(.FIFO_DEPTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .wr_en  (wr_en),
    .din    (din),
    .tx     (tx),
    .busy   (busy),
    .full   (full),
    .ovf    (ovf)
  );

  // 100 MHz-style free-running clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push one byte; starts and ends on a falling edge.
  task automatic write_byte(input logic [7:0] b);
    wr_en = 1'b1;
    din   = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // One baud pulse followed by the rest of the bit period.
  task automatic pulse();
    clk_en = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    repeat (GAP - 1) @(negedge clk);
  endtask

  // Walk a whole frame for byte b, checking every bit on the line.
  task automatic frame(input logic [7:0] b, input string tag);
    pulse();
    chk({tag, " start"}, tx, 1'b0);
    for (int i = 0; i < 8; i++) begin
      pulse();
      chk($sformatf("%s d%0d", tag, i), tx, b[i]);
    end
    pulse();
    chk({tag, " stop"}, tx, 1'b1);
    chk({tag, " busy_in_stop"}, busy, 1'b1);
  endtask

  initial begin
    rst    = 1'b1;
    clk_en = 1'b0;
    wr_en  = 1'b0;
    din    = 8'h00;
    exp_a5 = 10'b1101001010;
    @(negedge clk);
    @(negedge clk);
    chk("rst tx", tx, 1'b1);
    chk("rst busy", busy, 1'b0);
    chk("rst full", full, 1'b0);
    chk("rst ovf", ovf, 1'b0);
    rst = 1'b0;

    // Idle with baud pulses: nothing should happen.
    for (int k = 0; k < 3; k++) begin
      pulse();
      chk("idle tx", tx, 1'b1);
      chk("idle busy", busy, 1'b0);
      chk("idle full", full, 1'b0);
    end

    // Single 0xA5 frame; the write coincides with clk_en so it must not start yet.
    wr_en  = 1'b1;
    din    = 8'hA5;
    clk_en = 1'b1;
    @(negedge clk);
    wr_en  = 1'b0;
    clk_en = 1'b0;
    chk("a5 no_same_cycle_pop", tx, 1'b1);
    chk("a5 busy_rise", busy, 1'b1);
    repeat (GAP - 2) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      pulse();
      chk($sformatf("a5 bit%0d", i), tx, exp_a5[i]);
    end
    chk("a5 busy_in_stop", busy, 1'b1);
    pulse();
    chk("a5 busy_fall", busy, 1'b0);
    chk("a5 tx_idle", tx, 1'b1);

    // Three queued bytes go out with no idle bit between frames.
    write_byte(8'h00);
    write_byte(8'hFF);
    write_byte(8'h3C);
    frame(8'h00, "b2b0");
    frame(8'hFF, "b2b1");
    frame(8'h3C, "b2b2");
    pulse();
    chk("b2b busy_fall", busy, 1'b0);
    chk("b2b tx_idle", tx, 1'b1);

    // Overflow: fifth write into a depth-4 FIFO is dropped.
    write_byte(8'h11);
    chk("ovf full_after1", full, 1'b0);
    write_byte(8'h22);
    write_byte(8'h33);
    chk("ovf full_after3", full, 1'b0);
    write_byte(8'h44);
    chk("ovf full_after4", full, 1'b1);
    chk("ovf ovf_after4", ovf, 1'b0);
    write_byte(8'h55);
    chk("ovf ovf_pulse", ovf, 1'b1);
    chk("ovf still_full", full, 1'b1);
    @(negedge clk);
    chk("ovf ovf_clear", ovf, 1'b0);
    frame(8'h11, "ovf0");
    chk("ovf full_after_pop", full, 1'b0);
    frame(8'h22, "ovf1");
    frame(8'h33, "ovf2");
    frame(8'h44, "ovf3");
    pulse();
    chk("ovf no_fifth_frame", busy, 1'b0);
    chk("ovf tx_idle", tx, 1'b1);

    // Reset during d3 of 0x81 with two bytes queued.
    write_byte(8'h81);
    pulse();
    chk("rstmid start", tx, 1'b0);
    write_byte(8'hAA);
    write_byte(8'hBB);
    pulse();
    chk("rstmid d0", tx, 1'b1);
    pulse();
    chk("rstmid d1", tx, 1'b0);
    pulse();
    chk("rstmid d2", tx, 1'b0);
    pulse();
    chk("rstmid d3", tx, 1'b0);
    chk("rstmid busy_before", busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid tx", tx, 1'b1);
    chk("rstmid busy", busy, 1'b0);
    chk("rstmid full", full, 1'b0);
    for (int k = 0; k < 3; k++) begin
      pulse();
      chk("rstmid quiet_tx", tx, 1'b1);
      chk("rstmid quiet_busy", busy, 1'b0);
    end

    // Write while full in the same cycle as a STOP->START pop.
    write_byte(8'hC1);
    pulse();
    chk("popfull c1 start", tx, 1'b0);
    write_byte(8'hB2);
    write_byte(8'hC3);
    write_byte(8'hD4);
    write_byte(8'hE5);
    chk("popfull full", full, 1'b1);
    for (int i = 0; i < 8; i++) begin
      pulse();
      chk($sformatf("popfull c1 d%0d", i), tx, (8'hC1 >> i) & 8'h01);
    end
    pulse();
    chk("popfull c1 stop", tx, 1'b1);
    clk_en = 1'b1;
    wr_en  = 1'b1;
    din    = 8'h77;
    @(negedge clk);
    clk_en = 1'b0;
    wr_en  = 1'b0;
    chk("popfull ovf", ovf, 1'b1);
    chk("popfull full_drop", full, 1'b0);
    chk("popfull b2 start", tx, 1'b0);
    repeat (GAP - 2) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      pulse();
      chk($sformatf("popfull b2 d%0d", i), tx, (8'hB2 >> i) & 8'h01);
    end
    pulse();
    chk("popfull b2 stop", tx, 1'b1);
    frame(8'hC3, "popfull c3");
    frame(8'hD4, "popfull d4");
    frame(8'hE5, "popfull e5");
    pulse();
    chk("popfull dropped_not_sent", busy, 1'b0);
    chk("popfull tx_idle", tx, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
